// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory fetch responder.
//   - FSM state encodings (IDLE / WAIT / RESP) as legacy-compatible constants
//   - default store depth, default word-index width and default error instruction
//   - helper to size a word index from a store depth
package imem_pkg;

    typedef logic [1:0] imem_state_t;

    localparam imem_state_t ST_IDLE = 2'd0;
    localparam imem_state_t ST_WAIT = 2'd1;
    localparam imem_state_t ST_RESP = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEFAULT   = 32'h0000_0000;
    localparam int unsigned DEPTH_WORDS_DEFAULT = 256;
    localparam int unsigned IDX_W_DEFAULT       = $clog2(DEPTH_WORDS_DEFAULT);

    // Word-index width for a store of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: word-addressed instruction store.
//   One write port and two synchronous read ports. Each read port only updates its
//   output register when its enable is high, so the last read word is held.
//   A read and a write of the same index at the same edge return the old word.
// Ports:
//   clk                     clock
//   i_we/i_waddr/i_wdata    write port
//   i_re0/i_raddr0/o_rdata0 fetch read port
//   i_re1/i_raddr1/o_rdata1 next-line read port (prefetch path only)
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int unsigned IDX_W       = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re0,
    input  logic [IDX_W-1:0] i_raddr0,
    output logic [31:0]      o_rdata0,
    input  logic             i_re1,
    input  logic [IDX_W-1:0] i_raddr1,
    output logic [31:0]      o_rdata1
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re0) begin
            r_rdata0 <= r_mem[i_raddr0];
        end
        if (i_re1) begin
            r_rdata1 <= r_mem[i_raddr1];
        end
    end

    assign o_rdata0 = r_rdata0;
    assign o_rdata1 = r_rdata1;

endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: memory end of the instruction-fetch interface.
//   Accepts one fetch at a time (valid/ready), checks alignment and range, and returns
//   the word (or NOP_INSTR with an error flag) WAIT_CYCLES+1 cycles after the accept.
//   A load port writes the store in any state.
// Optional feature: define IMEM_PREFETCH_EN to add a one-entry next-line buffer;
//   a fetch hitting the buffer responds one cycle after accept.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_req_valid/o_req_ready        fetch request handshake
//   i_req_addr                     fetch byte address
//   o_rsp_valid/i_rsp_ready        response handshake
//   o_rsp_instr, o_rsp_err         response word and error flag
//   i_load_en/i_load_addr/i_load_data  store write port (addr bits [1:0] ignored)
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_instr,
    output logic              o_rsp_err,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [31:0]       i_load_data
);

    // ADDR_W must exceed IDX_W+2 so the range check has upper bits to inspect.
    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    imem_state_t      r_state;
    imem_state_t      w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    logic             w_accept;
    logic [IDX_W-1:0] w_req_idx;
    logic             w_req_err;
    logic             w_pf_hit;
    logic             r_err;
    logic             r_have_word;
    logic [31:0]      w_word;

    logic [IDX_W-1:0] w_ld_idx;
    logic             w_ld_we;
    logic             w_unused_load_lsb;

    logic [31:0]      w_rd0_data;
    logic [31:0]      w_rd1_data;
    logic             w_re1;
    logic [IDX_W-1:0] w_raddr1;

    // Request decode: power-of-two depth, so out of range means any upper bit set.
    assign w_accept  = i_req_valid && (r_state == ST_IDLE);
    assign w_req_idx = i_req_addr[IDX_W+1:2];
    assign w_req_err = (|i_req_addr[1:0]) || (|i_req_addr[ADDR_W-1:IDX_W+2]);

    // Load decode: out-of-range loads are dropped.
    assign w_ld_idx          = i_load_addr[IDX_W+1:2];
    assign w_ld_we           = i_load_en && !(|i_load_addr[ADDR_W-1:IDX_W+2]);
    assign w_unused_load_lsb = ^i_load_addr[1:0];

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk      (clk),
        .i_we     (w_ld_we),
        .i_waddr  (w_ld_idx),
        .i_wdata  (i_load_data),
        .i_re0    (w_accept),
        .i_raddr0 (w_req_idx),
        .o_rdata0 (w_rd0_data),
        .i_re1    (w_re1),
        .i_raddr1 (w_raddr1),
        .o_rdata1 (w_rd1_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic             r_pf_valid;
    logic [IDX_W-1:0] r_pf_idx;
    logic             r_sel_pf;
    logic [31:0]      r_hit_data;
    logic [IDX_W-1:0] w_nxt_idx;
    logic             w_nxt_ok;
    logic             w_pf_fill;

    assign w_nxt_idx = w_req_idx + IDX_W'(1);
    assign w_nxt_ok  = !(&w_req_idx);
    assign w_pf_fill = w_accept && !w_req_err && w_nxt_ok;
    assign w_pf_hit  = r_pf_valid && !w_req_err && (w_req_idx == r_pf_idx);
    assign w_re1     = w_pf_fill;
    assign w_raddr1  = w_nxt_idx;

    // The port-1 output register is the buffered next-line word; a hit copies it
    // out before the same edge overwrites it with the refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
            r_sel_pf   <= 1'b0;
            r_hit_data <= '0;
        end else begin
            if (w_accept) begin
                r_sel_pf <= w_pf_hit;
                if (w_pf_hit) begin
                    r_hit_data <= w_rd1_data;
                end
            end
            if (w_pf_fill) begin
                r_pf_valid <= 1'b1;
                r_pf_idx   <= w_nxt_idx;
            end
            // Any load may make the buffered word stale; it wins over a fill.
            if (i_load_en) begin
                r_pf_valid <= 1'b0;
            end
        end
    end

    assign w_word = r_sel_pf ? r_hit_data : w_rd0_data;
`else
    logic [31:0] w_unused_rd1;

    assign w_pf_hit     = 1'b0;
    assign w_re1        = 1'b0;
    assign w_raddr1     = '0;
    assign w_unused_rd1 = w_rd1_data;
    assign w_word       = w_rd0_data;
`endif

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_d   = '0;
                    w_state_d = (w_pf_hit || (WAIT_CYCLES == 0)) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_have_word <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_err       <= w_req_err;
                r_have_word <= 1'b1;
            end
        end
    end

    // The read register is not reset, so NOP_INSTR is shown until a word is fetched.
    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_err   = r_err;
    assign o_rsp_instr = (r_err || !r_have_word) ? NOP_INSTR : w_word;

endmodule

// File: tb/tb_imem_fetch_responder.sv
`timescale 1ns/1ps
module tb_imem_fetch_responder;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned WAIT   = 2;
    localparam logic [31:0] NOP    = 32'h0000_0000;
`ifdef IMEM_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic              rsp_err;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    always #5 clk = ~clk;

    imem_fetch_responder #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAIT),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_instr (rsp_instr),
        .o_rsp_err   (rsp_err),
        .i_load_en   (load_en),
        .i_load_addr (load_addr),
        .i_load_data (load_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding fetch, response due a fixed number of
    // edges after the accept edge, memory as a plain array.
    logic [31:0] m_mem [DEPTH];
    int          cyc        = 0;
    bit          m_busy     = 1'b0;
    int          m_valid_at = 0;
    logic [31:0] m_instr    = NOP;
    bit          m_err      = 1'b0;
    bit          m_pf_valid = 1'b0;
    int unsigned m_pf_idx   = 0;
    logic [31:0] m_pf_data  = NOP;

    task automatic model_step();
        bit          hs;
        bit          acc;
        bit          err;
        bit          hit;
        int unsigned idx;
        int unsigned lidx;
        if (rst) begin
            m_busy     = 1'b0;
            m_instr    = NOP;
            m_err      = 1'b0;
            m_pf_valid = 1'b0;
            cyc++;
            return;
        end
        hs  = m_busy && (cyc >= m_valid_at) && rsp_ready;
        acc = !m_busy && req_valid;
        cyc++;
        if (hs) m_busy = 1'b0;
        if (acc) begin
            idx = req_addr >> 2;
            err = (req_addr[1:0] != 2'b00) || (idx >= DEPTH);
            hit = PF && m_pf_valid && !err && (idx == m_pf_idx);
            m_instr    = err ? NOP : (hit ? m_pf_data : m_mem[idx]);
            m_err      = err;
            m_busy     = 1'b1;
            m_valid_at = cyc + (hit ? 0 : WAIT);
            if (PF && !err && (idx + 1 < DEPTH)) begin
                m_pf_valid = 1'b1;
                m_pf_idx   = idx + 1;
                m_pf_data  = m_mem[idx + 1];
            end
        end
        if (load_en) begin
            lidx = load_addr >> 2;
            if (lidx < DEPTH) m_mem[lidx] = load_data;
            m_pf_valid = 1'b0;
        end
    endtask

    task automatic compare_cycle();
        bit exp_valid;
        exp_valid = m_busy && (cyc >= m_valid_at);
        chk("model req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
        chk("model rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
        chk("model rsp_instr", rsp_instr, m_instr);
        chk("model rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) compare_cycle();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Issue one fetch from a negedge with the responder idle, optionally with a load
    // in the accept cycle, and check latency, response, hold and return to idle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_i, input bit exp_e,
                         input int exp_lat, input int hold,
                         input bit ld, input logic [31:0] ld_addr, input logic [31:0] ld_data);
        int lat;
        bit seen;
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = (hold == 0);
        load_en   = ld;
        load_addr = ld_addr;
        load_data = ld_data;
        @(negedge clk);
        req_valid = 1'b0;
        load_en   = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (rsp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("fetch latency", lat, exp_lat);
        chk("fetch rsp_instr", rsp_instr, exp_i);
        chk("fetch rsp_err", {31'b0, rsp_err}, {31'b0, exp_e});
        for (int k = 0; k < hold; k++) begin
            chk("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold rsp_instr", rsp_instr, exp_i);
            chk("hold req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post-handshake req_ready", {31'b0, req_ready}, 32'd1);
        chk("post-handshake rsp_valid", {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset rsp_instr", rsp_instr, NOP);
        chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        load(32'h0, 32'h11);
        load(32'h4, 32'h22);
        load(32'h8, 32'h33);
        load(32'hC, 32'h44);

        fetch(32'h4, 32'h22, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);
        fetch(32'h6, NOP, 1'b1, 3, 0, 1'b0, 32'h0, 32'h0);
        fetch(DEPTH * 4, NOP, 1'b1, 3, 0, 1'b0, 32'h0, 32'h0);
        fetch(32'hC, 32'h44, 1'b0, 3, 5, 1'b0, 32'h0, 32'h0);
        fetch(32'h8, 32'h33, 1'b0, 3, 0, 1'b1, 32'h8, 32'hAA);
        fetch(32'h8, 32'hAA, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);

        // Reset while the fetch sits in its wait phase: no response may appear.
        req_valid = 1'b1;
        req_addr  = 32'h4;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("in-wait req_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("after-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("after-reset req_ready", {31'b0, req_ready}, 32'd1);
            @(negedge clk);
        end

        fetch(32'h0, 32'h11, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);
`ifdef IMEM_PREFETCH_EN
        fetch(32'h4, 32'h22, 1'b0, 1, 0, 1'b0, 32'h0, 32'h0);
        fetch(32'h0, 32'h11, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);
        load(32'h40, 32'h99);
        fetch(32'h4, 32'h22, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);
`else
        fetch(32'h4, 32'h22, 1'b0, 3, 0, 1'b0, 32'h0, 32'h0);
`endif
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface whose initiator is the PC sequencer.
- Accepts one fetch address at a time over a valid/ready request channel and looks up a word-addressed instruction store.
- Returns the instruction word, or an error flag, over a valid/ready response channel after a fixed, parameterised latency.
- Provides a load port so the bench or boot logic can write program words before and during execution.

Parameters:
- ADDR_W, 32, width of fetch and load byte addresses.
- DEPTH_WORDS, 256, number of 32-bit words in the store (power of two).
- WAIT_CYCLES, 2, extra cycles between request accept and response valid (0 allowed).
- NOP_INSTR, 32'h0000_0000, instruction value returned on an error response.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address of the fetch (the PC).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  fetch side accepts the response.
- rsp_instr  out  32  fetched instruction, or NOP_INSTR on error.
- rsp_err  out  1  misaligned or out-of-range fetch.
- load_en  in  1  write enable for the store.
- load_addr  in  ADDR_W  byte address of the write; bits [1:0] are ignored.
- load_data  in  32  word to write.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_instr=NOP_INSTR, rsp_err=0, FSM in IDLE, wait counter 0. Store contents are NOT reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept happens at edge N when req_valid && req_ready.
  - idx = req_addr >> 2.
  - err = (req_addr[1:0] != 0) || (idx >= DEPTH_WORDS).
  - On accept, register rsp_instr = err ? NOP_INSTR : mem[idx] and rsp_err = err, both sampled at edge N.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT: counts WAIT_CYCLES cycles, then goes to RESP. req_ready=0.
- RESP:
  - rsp_valid=1, with rsp_valid first high in the cycle after edge N+WAIT_CYCLES.
  - rsp_instr and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge, return to IDLE; req_ready rises in the next cycle.
- Throughput: one fetch per WAIT_CYCLES+2 cycles when rsp_ready is held high.
- Errors take the same latency as normal fetches. The FSM never stalls or drops a request on error.
- Loads:
  - Accepted in any state.
  - mem[load_addr>>2] <= load_data when the index is in range; out-of-range loads are silently dropped.
  - A load to the in-flight address after edge N does not alter the registered response.
  - A load and a fetch of the same index at the same edge: the fetch returns the OLD word (read-before-write).
- Reset mid-operation: the in-flight fetch is discarded with no response emitted, and the FSM returns to IDLE.
- Address arithmetic is unsigned. No wrap: any idx >= DEPTH_WORDS is an error.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- Defined:
  - One-entry next-line buffer (pf_valid, pf_idx, pf_data). pf_valid resets to 0.
  - On every non-error accept of idx where idx+1 < DEPTH_WORDS: pf_idx <= idx+1, pf_data <= mem[idx+1], pf_valid <= 1.
  - An accept with pf_valid && idx == pf_idx is a hit: rsp_instr <= pf_data, FSM goes directly to RESP (1-cycle latency), and the buffer refills with idx+1.
  - Any load_en (any address) clears pf_valid at that edge; a concurrent fill is overridden.
- Undefined: no buffer, every fetch takes WAIT_CYCLES+1 cycles to rsp_valid.

Decomposition:
- Package imem_pkg holds the FSM state enum (IDLE/WAIT/RESP), NOP_INSTR default, and word-index width localparam (clog2 DEPTH_WORDS).
- Sub-module imem_array: storage with one write port and two synchronous read ports (second port used only by the prefetch path).
- FSM, error check and prefetch buffer live in the top.

Test Plan:
- Reset then load mem[0..3]=0x11,0x22,0x33,0x44; fetch addr 0x4, WAIT_CYCLES=2, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_instr=0x22, rsp_err=0, req_ready back 1 cycle after handshake.
- Fetch addr 0x6 and addr DEPTH_WORDS*4 -> each responds after the same latency with rsp_err=1, rsp_instr=0x0.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_instr/rsp_err stable, req_ready=0 throughout; first cycle after handshake returns to IDLE.
- Accept fetch 0x8 and at the same edge load 0x8 with 0xAA -> response 0x33; refetch 0x8 -> 0xAA.
- Assert rst during WAIT -> rsp_valid never asserts for that fetch, req_ready=1 after reset release.
- With IMEM_PREFETCH_EN: fetch 0x0 then 0x4 -> second rsp_valid 1 cycle after accept with 0x22; insert a load between them -> second fetch takes full latency.
